pc_stack_register: RTL and testbench
====================================

# pc_stack_register

Parametrised program-counter register: the next generation of the plain load/increment register. It adds signed relative jumps and a hardware return-address stack of configurable depth, so call and return complete in one cycle. It sits in the fetch path of the stack CPU, is driven by the control unit, and feeds the instruction-memory address.

## Interface
- DATA_SIZE, 11, width of the counter, of `in` and of each stack entry
- DEPTH, 8, number of return-address stack entries; must be ≥ 2
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in  input  DATA_SIZE  target address for load/call; signed two's-complement offset for rel
- load  input  1  absolute jump: out ← in
- rel  input  1  relative jump: out ← out + sign(in)
- inc  input  1  advance: out ← out + 1
- call  input  1  push out+1, then out ← in
- ret  input  1  pop: out ← top of stack
- out  output  DATA_SIZE  current program counter
- depth  output  $clog2(DEPTH+1)  number of valid stack entries
- full  output  1  depth == DEPTH
- empty  output  1  depth == 0
- err  output  1  sticky stack-fault flag (see Configuration)

## Operation
- Reset values: out = 0, depth = 0, empty = 1, full = 0, err = 0. Stack storage is not reset; contents are undefined until written.
- Command priority when several are high: rst > ret > call > load > rel > inc > hold. Only the highest-priority command acts. Lower commands in the same cycle are discarded.
- Arithmetic is modulo 2^DATA_SIZE.
  - inc from all-ones wraps to 0.
  - rel adds `in` as a signed value. For DATA_SIZE=11, in=0x7FF means −1.
- call:
  - Writes (out+1) mod 2^DATA_SIZE to entry[depth].
  - depth increments.
  - out ← in.
- ret, with depth > 0:
  - out ← entry[depth−1].
  - depth decrements.
- ret on empty: out and depth unchanged. err is set when RSTACK_GUARD_EN is defined.
- call on full: behaviour depends on RSTACK_GUARD_EN (see Configuration).
- full, empty and depth are combinational decodes of the depth register.
- err is cleared only by rst.

## Timing
- Every command takes effect on the rising clk edge at which it is sampled high. The result is visible on out, depth, full and empty in the following cycle.
- Single-cycle throughput: back-to-back call/ret on consecutive cycles is legal. A ret in the cycle after a call returns the address pushed by that call.
- No combinational path from inputs to outputs.
- rst asserted mid-sequence clears out, depth and err immediately, without waiting for clk. The stack contents become don't-care.
- Releasing rst is synchronous to clk. The first command is honoured at the first rising edge with rst low.

## Configuration
- Macro: RSTACK_GUARD_EN.
- Defined (guarded stack):
  - call on full: no push. out ← in still occurs. err ← 1.
  - ret on empty: no-op. err ← 1.
- Undefined (circular stack):
  - call on full overwrites the oldest entry. The stack behaves as a DEPTH-entry ring. depth stays DEPTH and the newest DEPTH return addresses are retained.
  - ret on empty: no-op.
  - err is constant 0.

## Test plan
DATA_SIZE=11, DEPTH=4 unless noted.
- Reset and increment:
  - Stimulus: rst pulse, then inc for 3 cycles.
  - Required: out=0 and empty=1 during rst; then out = 1, 2, 3.
- Wrap and relative:
  - Stimulus: load 0x7FE, inc, inc; then rel with in=0x7FE.
  - Required: out = 0x7FF, 0x000, then 0x7FE (offset −2).
- Nested call/return:
  - Stimulus: at out=0x010, call 0x100; call 0x200; ret; ret.
  - Required, in order:
    - out=0x100, depth=1
    - out=0x200, depth=2
    - out=0x101, depth=1
    - out=0x011, depth=0, empty=1
- Priority:
  - Stimulus: ret, call, load and inc all high with depth=1 and top=0x055.
  - Required: out=0x055, depth=0, no push.
- Overflow, guarded build:
  - Stimulus: 5 calls to 0x0A0..0x0A4 starting from out=0.
  - Required: full=1 after the 4th; the 5th leaves depth=4, sets out=0x0A4 and err=1.
  - Following 4 rets give out = 0x0A3, 0x0A2, 0x0A1, 0x001.
- Overflow, circular build:
  - Stimulus: same 5 calls, then 4 rets.
  - Required: err stays 0; rets give out = 0x0A4, 0x0A3, 0x0A2, 0x0A1.
  - A 5th ret is a no-op (out stays 0x0A1). Then assert rst asynchronously mid-cycle: out=0 and depth=0 before the next clk edge.

Source files
------------

// File: rtl/pc_stack_register.sv
// pc_stack_register: program counter with load, increment, signed relative
// jump and a single-cycle call/return address stack of DEPTH entries.
// Optional feature macro: RSTACK_GUARD_EN.
//   defined   - guarded stack: call on full does not push, ret on empty is a
//               no-op, both set the sticky err flag.
//   undefined - circular stack: call on full overwrites the oldest entry,
//               ret on empty is a no-op, err is constant 0.
module pc_stack_register #(
  parameter int DATA_SIZE = 11,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_SIZE-1:0]         in,
  input  logic                         load,
  input  logic                         rel,
  input  logic                         inc,
  input  logic                         call,
  input  logic                         ret,
  output logic [DATA_SIZE-1:0]         out,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty,
  output logic                         err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_REL,
    CMD_LOAD,
    CMD_CALL,
    CMD_RET
  } cmd_t;

  cmd_t                 cmd;
  logic [DATA_SIZE-1:0] entry [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        wr_ptr_inc;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr_next;
  logic [DATA_SIZE-1:0] out_next;
  logic [DW-1:0]        depth_next;
  logic [DATA_SIZE-1:0] ret_addr;
  logic                 push;
`ifdef RSTACK_GUARD_EN
  logic                 err_set;
`endif

  assign full       = (depth == DEPTH_MAX);
  assign empty      = (depth == '0);
  assign ret_addr   = out + DATA_SIZE'(1);

  // The stack is a ring addressed by a write pointer rather than by depth, so
  // the circular build can overwrite the oldest entry without shifting; when
  // no wrap has happened the pointer equals depth mod DEPTH.
  assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr     = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);

  // Priority decode of the command inputs: ret > call > load > rel > inc.
  always_comb begin
    cmd = CMD_HOLD;
    if (ret)       cmd = CMD_RET;
    else if (call) cmd = CMD_CALL;
    else if (load) cmd = CMD_LOAD;
    else if (rel)  cmd = CMD_REL;
    else if (inc)  cmd = CMD_INC;
  end

  // Next program counter, stack pointer, depth and push/fault strobes.
  always_comb begin
    out_next    = out;
    depth_next  = depth;
    wr_ptr_next = wr_ptr;
    push        = 1'b0;
`ifdef RSTACK_GUARD_EN
    err_set     = 1'b0;
`endif
    case (cmd)
      CMD_RET: begin
        if (!empty) begin
          out_next    = entry[rd_ptr];
          depth_next  = depth - DW'(1);
          wr_ptr_next = rd_ptr;
        end else begin
`ifdef RSTACK_GUARD_EN
          err_set = 1'b1;
`endif
        end
      end
      CMD_CALL: begin
        out_next = in;
        if (!full) begin
          push        = 1'b1;
          depth_next  = depth + DW'(1);
          wr_ptr_next = wr_ptr_inc;
        end else begin
`ifdef RSTACK_GUARD_EN
          err_set     = 1'b1;
`else
          push        = 1'b1;
          wr_ptr_next = wr_ptr_inc;
`endif
        end
      end
      CMD_LOAD: out_next = in;
      CMD_REL:  out_next = out + in;
      CMD_INC:  out_next = out + DATA_SIZE'(1);
      default:  out_next = out;
    endcase
  end

  // Counter, depth and stack pointer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out    <= '0;
      depth  <= '0;
      wr_ptr <= '0;
    end else begin
      out    <= out_next;
      depth  <= depth_next;
      wr_ptr <= wr_ptr_next;
    end
  end

  // Return-address storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (push && !rst) entry[wr_ptr] <= ret_addr;
  end

`ifdef RSTACK_GUARD_EN
  // Sticky stack-fault flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_register.sv
// Testbench for pc_stack_register (DATA_SIZE=11, DEPTH=4): directed scenarios
// followed by random commands, checked against a queue-based stack model.
module tb_pc_stack_register;

  localparam int DS = 11;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DS-1:0] in = '0;
  logic          load = 1'b0, rel = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [DS-1:0] out;
  logic [2:0]    depth;
  logic          full, empty, err;

  pc_stack_register #(.DATA_SIZE(DS), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .in(in), .load(load), .rel(rel), .inc(inc),
    .call(call), .ret(ret), .out(out), .depth(depth), .full(full),
    .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DS-1:0] pc;
    logic [2:0]    dep;
    logic          fl;
    logic          em;
    logic          er;
    string         name;
  } exp_t;

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;

  // Reference model: a plain queue of return addresses, newest at the back.
  logic [DS-1:0] m_pc = '0;
  logic [DS-1:0] m_stk[$];
  logic          m_err = 1'b0;

  function automatic exp_t snap(input string nm);
    exp_t e;
    e.pc   = m_pc;
    e.dep  = 3'(m_stk.size());
    e.fl   = (m_stk.size() == DP);
    e.em   = (m_stk.size() == 0);
    e.er   = m_err;
    e.name = nm;
    return e;
  endfunction

  function automatic void model_reset();
    m_pc = '0;
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  task automatic step(input logic r, input logic rt, input logic cl,
                      input logic ld, input logic rl, input logic ic,
                      input logic [DS-1:0] din, input string nm);
    logic [DS-1:0] junk;
    @(negedge clk);
    rst = r; ret = rt; call = cl; load = ld; rel = rl; inc = ic; in = din;
    if (r) begin
      model_reset();
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin
`ifdef RSTACK_GUARD_EN
        m_err = 1'b1;
`endif
      end
    end else if (cl) begin
      if (m_stk.size() < DP) m_stk.push_back(m_pc + 11'd1);
      else begin
`ifdef RSTACK_GUARD_EN
        m_err = 1'b1;
`else
        junk = m_stk.pop_front();
        m_stk.push_back(m_pc + 11'd1);
`endif
      end
      m_pc = din;
    end else if (ld) begin
      m_pc = din;
    end else if (rl) begin
      m_pc = DS'((int'(m_pc) + int'($signed(din)) + 4096) % 2048);
    end else if (ic) begin
      m_pc = m_pc + 11'd1;
    end
    sb.push_back(snap(nm));
  endtask

  // Reset asserted between clock edges; checked before the next edge.
  task automatic async_reset_midcycle();
    @(posedge clk);
    #2;
    model_reset();
    sb.push_back(snap("async_rst"));
    ret = 0; call = 0; load = 0; rel = 0; inc = 0;
    rst = 1'b1;
  endtask

  // Monitor: outputs are presented after every clock edge and on async reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (out !== e.pc || depth !== e.dep || full !== e.fl ||
            empty !== e.em || err !== e.er) begin
          miscompares++;
          $display("FAIL %s @%0t: got out=%h depth=%0d full=%b empty=%b err=%b, want out=%h depth=%0d full=%b empty=%b err=%b",
                   e.name, $time, out, depth, full, empty, err,
                   e.pc, e.dep, e.fl, e.em, e.er);
        end
      end
    end
  end

  initial begin
    model_reset();
    // reset and increment
    step(1, 0, 0, 0, 0, 0, '0, "reset");
    step(0, 0, 0, 0, 0, 1, '0, "inc1");
    step(0, 0, 0, 0, 0, 1, '0, "inc2");
    step(0, 0, 0, 0, 0, 1, '0, "inc3");
    // wrap and relative
    step(0, 0, 0, 1, 0, 0, 11'h7FE, "load7fe");
    step(0, 0, 0, 0, 0, 1, '0, "inc7ff");
    step(0, 0, 0, 0, 0, 1, '0, "wrap0");
    step(0, 0, 0, 0, 1, 0, 11'h7FE, "rel_m2");
    // nested call/return
    step(0, 0, 0, 1, 0, 0, 11'h010, "load010");
    step(0, 0, 1, 0, 0, 0, 11'h100, "call100");
    step(0, 0, 1, 0, 0, 0, 11'h200, "call200");
    step(0, 1, 0, 0, 0, 0, '0, "ret101");
    step(0, 1, 0, 0, 0, 0, '0, "ret011");
    // priority: top=0x055, depth=1, then ret+call+load+inc together
    step(0, 0, 0, 1, 0, 0, 11'h054, "load054");
    step(0, 0, 1, 0, 0, 0, 11'h300, "call300");
    step(0, 1, 1, 1, 0, 1, 11'h123, "prio");
    step(0, 1, 0, 0, 0, 0, '0, "ret_empty");
    // overflow: 5 calls, 5 rets, then async reset mid-cycle
    step(1, 0, 0, 0, 0, 0, '0, "reset2");
    for (int unsigned i = 0; i < 5; i++)
      step(0, 0, 1, 0, 0, 0, 11'h0A0 + 11'(i), "ovf_call");
    for (int unsigned i = 0; i < 5; i++)
      step(0, 1, 0, 0, 0, 0, '0, "ovf_ret");
    async_reset_midcycle();
    step(1, 0, 0, 0, 0, 0, '0, "rst_hold");
    // back-to-back call then ret
    step(0, 0, 1, 0, 0, 0, 11'h3C0, "b2b_call");
    step(0, 1, 0, 0, 0, 0, '0, "b2b_ret");
    // random commands
    for (int unsigned i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 15,
           $urandom_range(0, 99) < 40,
           DS'($urandom), "rand");
    end
    step(0, 0, 0, 0, 0, 0, '0, "idle");
    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
